// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the ID-stage pipeline controller (slave) and the
// datapath that feeds it and consumes its stall/flush decisions (master).
interface pipe_ctrl_if;
    logic [15:0] ins_id;
    logic        id_valid;
    logic        wb_write_flag;
    logic [2:0]  wb_write_addr;
    logic        branch_taken;
    logic        issue;
    logic        stall;
    logic        bubble_ex;
    logic        flush_ifid;
    logic [7:0]  pending;
    logic [15:0] stall_cnt;

    modport master (
        output ins_id, id_valid, wb_write_flag, wb_write_addr, branch_taken,
        input  issue, stall, bubble_ex, flush_ifid, pending, stall_cnt
    );

    modport slave (
        input  ins_id, id_valid, wb_write_flag, wb_write_addr, branch_taken,
        output issue, stall, bubble_ex, flush_ifid, pending, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// ID-stage hazard controller: register scoreboard, RUN/FLUSH branch FSM and a saturating stall counter.
// Optional build macro PIPE_CTRL_WB_BYPASS_EN: reads of a register being written back this cycle do not hazard.
module pipe_ctrl (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  pending_q;
    logic [15:0] stall_cnt_q;

    logic [3:0]  opcode;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [2:0]  dest;
    logic        rd_src1;
    logic        rd_src2;
    logic        wr_dest;
    logic [7:0]  wb_mask;
    logic [7:0]  read_pending;
    logic        hazard;
    logic        issue_c;
    logic        stall_c;
    logic        bubble_c;
    logic        flush_c;
    logic [7:0]  pending_nxt;
    logic        unused_ins_bits;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Set is applied after clear so a new writer wins over a retiring one.
    function automatic logic [7:0] next_pending(input logic [7:0] cur,
                                                input logic       clr,
                                                input logic [2:0] clr_addr,
                                                input logic       set,
                                                input logic [2:0] set_addr);
        logic [7:0] n;
        n = cur;
        if (clr) n[clr_addr] = 1'b0;
        if (set) n[set_addr] = 1'b1;
        n[0] = 1'b0;
        return n;
    endfunction

    assign unused_ins_bits = ^bus.ins_id[2:0];

    always_comb begin
        opcode  = bus.ins_id[15:12];
        src1    = bus.ins_id[11:9];
        src2    = bus.ins_id[8:6];
        dest    = bus.ins_id[5:3];
        rd_src1 = 1'b0;
        rd_src2 = 1'b0;
        wr_dest = 1'b0;
        if (opcode == 4'h0) begin
            rd_src1 = 1'b1;
            rd_src2 = 1'b1;
            wr_dest = 1'b1;
        end else if (opcode <= 4'h7) begin
            rd_src1 = 1'b1;
            wr_dest = 1'b1;
            dest    = bus.ins_id[8:6];
        end else if (opcode != 4'hF) begin
            rd_src1 = 1'b1;
            rd_src2 = 1'b1;
        end
    end

    assign wb_mask = bus.wb_write_flag ? (8'h01 << bus.wb_write_addr) : 8'h00;

`ifdef PIPE_CTRL_WB_BYPASS_EN
    // Write-through register file: the value being written is already visible to the reader.
    assign read_pending = pending_q & ~wb_mask;
`else
    assign read_pending = pending_q;
`endif

    // The destination check always uses the raw scoreboard: WAW is never bypassed.
    assign hazard = bus.id_valid & ((rd_src1 & read_pending[src1]) |
                                    (rd_src2 & read_pending[src2]) |
                                    (wr_dest & pending_q[dest]));

    always_comb begin
        issue_c  = 1'b0;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        if (!rst) begin
            issue_c = 1'b0;
        end else if (state == FLUSH || bus.branch_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
        end else if (hazard) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
        end else begin
            issue_c = bus.id_valid;
        end
    end

    assign pending_nxt = next_pending(pending_q,
                                      bus.wb_write_flag, bus.wb_write_addr,
                                      issue_c & wr_dest, dest);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            pending_q   <= 8'h00;
            stall_cnt_q <= 16'h0000;
        end else begin
            case (state)
                RUN:     if (bus.branch_taken) state <= FLUSH;
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
            pending_q <= pending_nxt & ~(wb_mask & 8'h00) ;
            if (stall_c) stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign bus.issue      = issue_c;
    assign bus.stall      = stall_c;
    assign bus.bubble_ex  = bubble_c;
    assign bus.flush_ifid = flush_c;
    assign bus.pending    = pending_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic against a scoreboard-level reference model.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();
    pipe_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  m_pend;
    bit          m_flush;
    int unsigned m_cnt;

    typedef struct {
        logic [15:0] ins;
        logic        v;
        logic        wbf;
        logic [2:0]  wba;
        logic        br;
        logic [3:0]  exp_ctl;
        logic [7:0]  exp_pend;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [15:0] enc(input int op, input int s1, input int s2, input int rd);
        logic [15:0] w;
        w = 16'h0000;
        w[15:12] = op[3:0];
        w[11:9]  = s1[2:0];
        w[8:6]   = s2[2:0];
        w[5:3]   = rd[2:0];
        return w;
    endfunction

    function automatic logic [3:0] ctl();
        return {bus.issue, bus.stall, bus.bubble_ex, bus.flush_ifid};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [15:0] ins, input logic v, input logic wbf,
                         input logic [2:0] wba, input logic br);
        bus.ins_id        = ins;
        bus.id_valid      = v;
        bus.wb_write_flag = wbf;
        bus.wb_write_addr = wba;
        bus.branch_taken  = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(16'hF000, 1'b0, 1'b0, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_pend  = 8'h00;
        m_flush = 1'b0;
        m_cnt   = 0;
    endtask

    // Reference: which registers an instruction reads and which it writes (-1 = none).
    function automatic void decode(input logic [15:0] ins, output logic [7:0] rmask, output int dst);
        int op;
        op    = int'(ins[15:12]);
        rmask = 8'h00;
        dst   = -1;
        if (op == 0) begin
            rmask[ins[11:9]] = 1'b1;
            rmask[ins[8:6]]  = 1'b1;
            dst = int'(ins[5:3]);
        end else if (op <= 7) begin
            rmask[ins[11:9]] = 1'b1;
            dst = int'(ins[8:6]);
        end else if (op <= 14) begin
            rmask[ins[11:9]] = 1'b1;
            rmask[ins[8:6]]  = 1'b1;
        end
    endfunction

    task automatic model_cycle(input logic [15:0] ins, input logic v, input logic wbf,
                               input logic [2:0] wba, input logic br);
        logic [7:0] rmask;
        logic [7:0] visible;
        int         dst;
        bit         haz;
        logic [3:0] exp_ctl;
        drive(ins, v, wbf, wba, br);
        decode(ins, rmask, dst);
        visible = m_pend;
`ifdef PIPE_CTRL_WB_BYPASS_EN
        if (wbf) visible[wba] = 1'b0;
`endif
        haz = v && (((rmask & visible) != 8'h00) || (dst >= 0 && m_pend[dst]));
        if (m_flush || br) exp_ctl = 4'b0011;
        else if (haz)      exp_ctl = 4'b0110;
        else               exp_ctl = {v, 3'b000};
        @(negedge clk);
        check("rand_ctl", ctl(), exp_ctl);
        check("rand_pend", bus.pending, m_pend);
        check("rand_cnt", bus.stall_cnt, m_cnt);
        if (exp_ctl[2] && m_cnt < 65535) m_cnt++;
        if (wbf) m_pend[wba] = 1'b0;
        if (exp_ctl[3] && dst > 0) m_pend[dst] = 1'b1;
        m_flush = m_flush ? 1'b0 : br;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          extra;
        bit          issued;
        logic [2:0]  a;

        do_reset();

        // Directed table: R0 writes, set/clear collision, WAW, branch during a stall.
        tbl[0]  = '{16'h0000,       1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h00, 16'd0};
        tbl[1]  = '{enc(1,0,0,0),   1'b1, 1'b0, 3'd0, 1'b0, 4'b1000, 8'h00, 16'd0};
        tbl[2]  = '{enc(0,0,0,1),   1'b1, 1'b0, 3'd0, 1'b0, 4'b1000, 8'h00, 16'd0};
        tbl[3]  = '{enc(1,2,5,0),   1'b1, 1'b1, 3'd5, 1'b0, 4'b1000, 8'h02, 16'd0};
        tbl[4]  = '{enc(1,0,3,0),   1'b1, 1'b0, 3'd0, 1'b0, 4'b1000, 8'h22, 16'd0};
        tbl[5]  = '{enc(2,0,3,0),   1'b1, 1'b0, 3'd0, 1'b0, 4'b0110, 8'h2A, 16'd0};
        tbl[6]  = '{enc(2,0,3,0),   1'b1, 1'b1, 3'd3, 1'b0, 4'b0110, 8'h2A, 16'd1};
        tbl[7]  = '{enc(2,0,3,0),   1'b1, 1'b0, 3'd0, 1'b0, 4'b1000, 8'h22, 16'd2};
        tbl[8]  = '{enc(8,3,1,0),   1'b1, 1'b0, 3'd0, 1'b1, 4'b0011, 8'h2A, 16'd2};
        tbl[9]  = '{enc(8,3,1,0),   1'b1, 1'b0, 3'd0, 1'b1, 4'b0011, 8'h2A, 16'd2};
        tbl[10] = '{enc(8,3,1,0),   1'b1, 1'b0, 3'd0, 1'b0, 4'b0110, 8'h2A, 16'd2};
        tbl[11] = '{16'h0000,       1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 8'h2A, 16'd3};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].ins, tbl[i].v, tbl[i].wbf, tbl[i].wba, tbl[i].br);
            @(negedge clk);
            check($sformatf("tbl%0d_ctl", i), ctl(), tbl[i].exp_ctl);
            check($sformatf("tbl%0d_pend", i), bus.pending, tbl[i].exp_pend);
            check($sformatf("tbl%0d_cnt", i), bus.stall_cnt, tbl[i].exp_cnt);
            tick();
        end

        // RAW: 0x1A45 writes R1, 0x0298 reads R1 and stalls until R1 is written back.
        do_reset();
        drive(16'h1A45, 1'b1, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        check("raw_first_issue", ctl(), 4'b1000);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(16'h0298, 1'b1, 1'b0, 3'd0, 1'b0);
            @(negedge clk);
            check("raw_stall", ctl(), 4'b0110);
            check("raw_pend", bus.pending, 8'h02);
            tick();
        end
        extra  = 0;
        issued = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(16'h0298, 1'b1, (k == 0), 3'd1, 1'b0);
            @(negedge clk);
            if (bus.issue) begin
                issued = 1'b1;
                tick();
                break;
            end
            if (bus.stall) extra++;
            tick();
        end
        check("raw_issued", issued, 1'b1);
`ifdef PIPE_CTRL_WB_BYPASS_EN
        check("raw_extra_stalls", extra, 0);
`else
        check("raw_extra_stalls", extra, 1);
`endif
        drive(16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        check("raw_pend_after", bus.pending, 8'h08);
        tick();

        // Reset asserted asynchronously in the middle of a stall.
        do_reset();
        drive(16'h1A45, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        drive(16'h0298, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        #2;
        check("rstmid_pre_ctl", ctl(), 4'b0110);
        rst = 1'b0;
        #1;
        check("rstmid_ctl", ctl(), 4'b0000);
        check("rstmid_pend", bus.pending, 8'h00);
        check("rstmid_cnt", bus.stall_cnt, 16'd0);
        drive(16'h0298, 1'b1, 1'b0, 3'd0, 1'b1);
        #1;
        check("rstmid_br_ctl", ctl(), 4'b0000);
        tick();
        drive(16'h0298, 1'b1, 1'b0, 3'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rstrel_ctl", ctl(), 4'b1000);
        check("rstrel_pend", bus.pending, 8'h00);
        check("rstrel_cnt", bus.stall_cnt, 16'd0);
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            a = 3'($urandom_range(7, 0));
            for (int t = 0; t < 16; t++) begin
                if (m_pend == 8'h00 || m_pend[a]) break;
                a = 3'($urandom_range(7, 1));
            end
            model_cycle(16'($urandom), ($urandom % 8) != 0, ($urandom % 3) == 0, a,
                        ($urandom % 16) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
